capture_readout_sequencer: RTL and testbench
============================================

# capture_readout_sequencer

Downstream stage of `logic_analyzer_core`. After a capture completes, the block reads the circular sample BRAM in chronological order, starting `PRE_TRIGGER` samples before the trigger point. It emits the samples as a framed byte stream (header, samples, checksum) over a valid/ready handshake to the UART transmitter. It owns the BRAM read port; the core owns the write port.

## Interface
- `ADDR_WIDTH`, 11: BRAM address width. Legal range 4..16. DEPTH = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: sample width. Fixed at 8; any other value is illegal.
- `PRE_TRIGGER`, 1024: samples sent before the trigger sample. Legal range 0..DEPTH-1.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `capture_done`  in  1: level signal from the core. Its rising edge starts readout.
- `trigger_index`  in  ADDR_WIDTH: BRAM address of the trigger sample. Sampled on the start edge.
- `abort`  in  1: synchronous cancel.
- `rd_en`  out  1: BRAM read strobe.
- `rd_addr`  out  ADDR_WIDTH: BRAM read address.
- `rd_data`  in  8: BRAM output. Registered, valid 1 cycle after `rd_en`.
- `tx_data`  out  8: stream byte.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: sink accepts a byte.
- `busy`  out  1: high in every state except IDLE.
- `readout_done`  out  1: one-cycle pulse on normal frame completion.

## Operation
- Frame format is 4 + DEPTH + 1 bytes:
  - 0xA5, 0x5A
  - TIH = trigger_index[ADDR_WIDTH-1:8] zero-extended to 8 bits (0x00 when ADDR_WIDTH ≤ 8)
  - TIL = trigger_index[7:0]
  - DEPTH sample bytes
  - checksum CK = XOR of all sample bytes, initial value 0x00. Header bytes are excluded.
- Start address: S = (trigger_index_latched − PRE_TRIGGER) mod DEPTH. The ADDR_WIDTH-bit subtraction wraps naturally.
- Sample k (k = 0..DEPTH-1) is read from (S + k) mod DEPTH. The address wraps from DEPTH-1 to 0.
- States and transitions:
  - IDLE: on a `capture_done` rising edge, latch `trigger_index`, clear the sample count and CK, go to HDR.
  - HDR: present header bytes 0..3. The byte index advances on each transfer. After byte 3 transfers, go to RD.
  - RD: `rd_en`=1, `rd_addr`=S+k. Go to WAIT.
  - WAIT: capture `rd_data` into `tx_data`, set `tx_valid`, XOR `rd_data` into CK. Go to SEND.
  - SEND: hold until transfer, then k++. If k was DEPTH-1, go to CK. Otherwise go to RD.
  - CK: present CK. On transfer, go to DONE.
  - DONE: `readout_done`=1 for one cycle, then IDLE.
- Edge detection uses a registered copy of `capture_done` that resets to 0. A `capture_done` level already high at reset release therefore starts a frame.
- Rising edges of `capture_done` outside IDLE are ignored and not queued.
- `abort` has priority over every transition:
  - Next cycle: state IDLE, `tx_valid`=0, `rd_en`=0.
  - No `readout_done` pulse.
  - A partially transferred byte is dropped. This is the only case where `tx_valid` falls without a transfer.
  - In IDLE, `abort` has no effect.

## Timing
- Transfer occurs when `tx_valid` && `tx_ready` at a posedge.
- While `tx_valid`=1 and no transfer occurs, `tx_data` is stable.
- `tx_valid` never depends combinationally on `tx_ready`.
- Start latency: edge at posedge N is detected at N; state HDR and `tx_valid`=1 with 0xA5 from cycle N+1.
- Header: with `tx_ready` high, one byte per cycle, so 4 consecutive cycles of `tx_valid`.
- Samples: minimum 3 cycles per byte (RD, WAIT, SEND). `tx_valid` is low in RD and WAIT.
- CK: valid the cycle after the last sample transfers.
- Minimum frame length with `tx_ready` held high: 4 + 3·DEPTH + 1 cycles of streaming, plus 1 DONE cycle.
- `rd_en` is high for exactly one cycle per sample. It is low in all other states.
- Reset values:
  - outputs: `rd_en`, `rd_addr`, `tx_data`, `tx_valid`, `busy`, `readout_done` all 0
  - internals: state IDLE, CK 0, count 0
- Reset asserted mid-frame: outputs take reset values immediately (asynchronous). No resume.

## Structure
- Shared package `la_pkg`:
  - state enum
  - constants SYNC0=0xA5, SYNC1=0x5A, HDR_LEN=4
- No sub-module is needed. A single FSM plus counters, roughly 150–250 lines.

## Test plan
Setup for all scenarios: ADDR_WIDTH=4, PRE_TRIGGER=4, BRAM model with 1-cycle read latency, mem[i]=i except mem[5]=0xFF.

1. trigger_index=2, `tx_ready`=1 → stream is A5 5A 00 02, then 0E 0F 00 01 02 03 04 FF 06 07 08 09 0A 0B 0C 0D, then CK=0xFA. `readout_done` pulses once; frame takes 4+48+1 cycles.
2. Same setup with random `tx_ready` (≈30% duty) → byte sequence is identical. `tx_data` never changes while `tx_valid` && !`tx_ready`.
3. trigger_index=4 (S=0, no wrap) → samples 00..0F in order with mem[5]=FF. `rd_addr` sequence is 0..15, exactly 16 `rd_en` pulses.
4. Assert `abort` during sample 7 in SEND → next cycle IDLE, `tx_valid`=0, no `readout_done`. A new `capture_done` edge then yields a complete, correct frame.
5. Second `capture_done` rising edge during HDR → ignored. Exactly one frame is sent, and TIL equals the first latched index.
6. Deassert `rst_n` mid-data → all outputs 0 asynchronously. After release, with `capture_done` still high, a fresh full frame starts.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the capture readout sequencer: FSM state encoding,
// frame header constants and small byte-level helpers.
package la_pkg;

    // Readout sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_SEND = 3'd4,
        ST_CK   = 3'd5,
        ST_DONE = 3'd6
    } seq_state_e;

    // Frame sync bytes and header length
    localparam logic [7:0] SYNC0   = 8'hA5;
    localparam logic [7:0] SYNC1   = 8'h5A;
    localparam int         HDR_LEN = 4;

    // Index of the last header byte
    localparam logic [1:0] HDR_LAST_IDX = 2'(HDR_LEN - 1);

    // Header byte selector. trig16 is the latched trigger index zero-extended
    // to 16 bits, so the high byte is naturally 0x00 for narrow addresses.
    function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                            input logic [15:0] trig16);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC0;
            2'd1:    b = SYNC1;
            2'd2:    b = trig16[15:8];
            2'd3:    b = trig16[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Running XOR checksum over sample bytes
    function automatic logic [7:0] ck_update(input logic [7:0] ck,
                                             input logic [7:0] data);
        return ck ^ data;
    endfunction

endpackage

// File: rtl/capture_readout_sequencer_if.sv
// BRAM read port plus outgoing byte stream of the readout sequencer.
// master = sequencer side, slave = BRAM/UART side.
interface capture_readout_sequencer_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) ();

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/capture_readout_sequencer.sv
// Reads the circular capture BRAM in chronological order starting PRE_TRIGGER
// samples before the trigger and streams a framed byte sequence:
// A5 5A TIH TIL <DEPTH samples> CK. All outputs are registered; tx_valid never
// depends combinationally on tx_ready.
module capture_readout_sequencer
    import la_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int PRE_TRIGGER = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture_done,
    input  logic [ADDR_WIDTH-1:0] trigger_index,
    input  logic                  abort,
    output logic                  busy,
    output logic                  readout_done,
    capture_readout_sequencer_if.master bus
);

    // Offset subtracted from the trigger address; the subtraction wraps mod DEPTH
    localparam logic [ADDR_WIDTH-1:0] PRE_OFS  = ADDR_WIDTH'(PRE_TRIGGER);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    seq_state_e state_q, state_d;

    logic                  cap_prev_q, cap_prev_d;
    logic [ADDR_WIDTH-1:0] trig_q, trig_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [7:0]            ck_q, ck_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  readout_done_q, readout_done_d;

    logic                  start_s;
    logic                  xfer_s;
    logic                  last_sample_s;
    logic [ADDR_WIDTH-1:0] start_addr_s;
    logic [15:0]           trig_ext_s;
    logic [1:0]            hdr_next_idx_s;

    // Decode of edges, transfers and derived addresses
    always_comb begin
        start_s        = capture_done & ~cap_prev_q;
        xfer_s         = tx_valid_q & bus.tx_ready;
        last_sample_s  = (cnt_q == LAST_IDX);
        start_addr_s   = trig_q - PRE_OFS;
        trig_ext_s     = 16'(trig_q);
        hdr_next_idx_s = hdr_idx_q + 2'd1;
    end

    // Next-state and next-output logic; abort outside IDLE overrides everything
    always_comb begin
        state_d        = state_q;
        cap_prev_d     = capture_done;
        trig_d         = trig_q;
        cnt_d          = cnt_q;
        hdr_idx_d      = hdr_idx_q;
        ck_d           = ck_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        readout_done_d = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            // Any byte in flight is dropped; no completion pulse
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            rd_en_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        trig_d     = trigger_index;
                        cnt_d      = CNT_ZERO;
                        ck_d       = 8'h00;
                        hdr_idx_d  = 2'd0;
                        tx_data_d  = SYNC0;
                        tx_valid_d = 1'b1;
                        state_d    = ST_HDR;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end

                ST_HDR: begin
                    if (xfer_s) begin
                        if (hdr_idx_q == HDR_LAST_IDX) begin
                            hdr_idx_d  = 2'd0;
                            tx_valid_d = 1'b0;
                            rd_en_d    = 1'b1;
                            rd_addr_d  = start_addr_s + cnt_q;
                            state_d    = ST_RD;
                        end else begin
                            hdr_idx_d  = hdr_next_idx_s;
                            tx_data_d  = hdr_byte(hdr_next_idx_s, trig_ext_s);
                            tx_valid_d = 1'b1;
                        end
                    end else begin
                        tx_valid_d = 1'b1;
                    end
                end

                ST_RD: begin
                    // BRAM output becomes valid during WAIT
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT;
                end

                ST_WAIT: begin
                    tx_data_d  = bus.rd_data;
                    tx_valid_d = 1'b1;
                    ck_d       = ck_update(ck_q, bus.rd_data);
                    state_d    = ST_SEND;
                end

                ST_SEND: begin
                    if (xfer_s) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (last_sample_s) begin
                            // ck_q already folds in the last sample
                            tx_data_d  = ck_q;
                            tx_valid_d = 1'b1;
                            state_d    = ST_CK;
                        end else begin
                            tx_valid_d = 1'b0;
                            rd_en_d    = 1'b1;
                            rd_addr_d  = start_addr_s + cnt_q + CNT_ONE;
                            state_d    = ST_RD;
                        end
                    end else begin
                        tx_valid_d = 1'b1;
                    end
                end

                ST_CK: begin
                    if (xfer_s) begin
                        tx_valid_d     = 1'b0;
                        readout_done_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        tx_valid_d = 1'b1;
                    end
                end

                ST_DONE: begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end

                default: begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_prev_q     <= 1'b0;
            trig_q         <= CNT_ZERO;
            cnt_q          <= CNT_ZERO;
            hdr_idx_q      <= 2'd0;
            ck_q           <= 8'h00;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= CNT_ZERO;
            tx_data_q      <= {DATA_WIDTH{1'b0}};
            tx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            readout_done_q <= 1'b0;
        end else begin
            cap_prev_q     <= cap_prev_d;
            trig_q         <= trig_d;
            cnt_q          <= cnt_d;
            hdr_idx_q      <= hdr_idx_d;
            ck_q           <= ck_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            busy_q         <= busy_d;
            readout_done_q <= readout_done_d;
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = busy_q;
    assign readout_done = readout_done_q;

endmodule

// File: tb/tb_capture_readout_sequencer.sv
// Directed bench for capture_readout_sequencer with ADDR_WIDTH=4, PRE_TRIGGER=4
// and a 1-cycle-latency BRAM holding mem[i]=i except mem[5]=0xFF.
module tb_capture_readout_sequencer;

    localparam int AW    = 4;
    localparam int PRE   = 4;
    localparam int DEPTH = 16;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture_done = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] trigger_index = 4'd0;
    logic          busy;
    logic          readout_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [DEPTH];

    // Hand-computed frames: trigger 2 (S=14, wraps) and trigger 4 (S=0)
    logic [7:0] exp1 [21] = '{8'hA5, 8'h5A, 8'h00, 8'h02,
                              8'h0E, 8'h0F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF,
                              8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                              8'hFA};
    logic [7:0] exp3 [21] = '{8'hA5, 8'h5A, 8'h00, 8'h04,
                              8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                              8'hFA};

    capture_readout_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) bus ();

    capture_readout_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (8),
        .PRE_TRIGGER(PRE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_done (capture_done),
        .trigger_index(trigger_index),
        .abort        (abort),
        .busy         (busy),
        .readout_done (readout_done),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // BRAM model with registered read data
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Monitor state
    logic [7:0]    xfer_q[$];
    logic [AW-1:0] addr_q[$];
    int            done_cnt = 0;
    int            busy_cycles = 0;
    int            hold_viol = 0;
    logic          prev_hold = 1'b0;
    logic [7:0]    prev_data = 8'h00;

    // Stream monitor sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) xfer_q.push_back(bus.tx_data);
            if (prev_hold && bus.tx_valid && (bus.tx_data !== prev_data)) hold_viol++;
            prev_hold = bus.tx_valid && !bus.tx_ready;
            prev_data = bus.tx_data;
            if (bus.rd_en) addr_q.push_back(bus.rd_addr);
            if (readout_done) done_cnt++;
            if (busy) busy_cycles++;
        end
    end

    function automatic byte_q_t build_expected(input logic [AW-1:0] trig);
        byte_q_t    q;
        logic [7:0] ck;
        logic [AW-1:0] s;
        logic [AW-1:0] a;
        s = trig - 4'(PRE);
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'h5A);
        q.push_back(8'h00);
        q.push_back({4'h0, trig});
        ck = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            a = s + 4'(k);
            q.push_back(mem[a]);
            ck = ck ^ mem[a];
        end
        q.push_back(ck);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] trig);
        capture_done = 1'b0;
        tick();
        xfer_q.delete();
        addr_q.delete();
        done_cnt    = 0;
        busy_cycles = 0;
        hold_viol   = 0;
        trigger_index = trig;
        capture_done  = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget, input bit rnd, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rnd) bus.tx_ready = ($urandom_range(0, 9) < 3);
            tick();
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
        checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.rd_addr !== 4'h0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (readout_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", readout_done); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic_frame();
        bit to;
        bus.tx_ready = 1'b1;
        start_frame(4'd2);
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5 || busy !== 1'b1) begin
            failures++; $display("FAIL start_latency valid=%b data=%h busy=%b exp=1/A5/1", bus.tx_valid, bus.tx_data, busy);
        end
        wait_idle(300, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout busy still high"); end
        checks++; if (xfer_q.size() != 21) begin
            failures++; $display("FAIL basic_len got=%0d exp=21", xfer_q.size());
        end else begin
            for (int i = 0; i < 21; i++) begin
                checks++; if (xfer_q[i] !== exp1[i]) begin failures++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp1[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy_cycles != 54) begin failures++; $display("FAIL basic_frame_cycles got=%0d exp=54", busy_cycles); end
        checks++; if (addr_q.size() != 16) begin failures++; $display("FAIL basic_rd_en_pulses got=%0d exp=16", addr_q.size()); end
    endtask

    task automatic test_backpressure();
        bit to;
        bus.tx_ready = 1'b0;
        start_frame(4'd2);
        wait_idle(3000, 1'b1, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout busy still high"); end
        checks++; if (xfer_q.size() != 21) begin
            failures++; $display("FAIL bp_len got=%0d exp=21", xfer_q.size());
        end else begin
            for (int i = 0; i < 21; i++) begin
                checks++; if (xfer_q[i] !== exp1[i]) begin failures++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp1[i]); end
            end
        end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_data_stable violations=%0d exp=0", hold_viol); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_no_wrap();
        bit to;
        bus.tx_ready = 1'b1;
        start_frame(4'd4);
        wait_idle(300, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL nowrap_timeout busy still high"); end
        checks++; if (xfer_q.size() != 21) begin
            failures++; $display("FAIL nowrap_len got=%0d exp=21", xfer_q.size());
        end else begin
            for (int i = 0; i < 21; i++) begin
                checks++; if (xfer_q[i] !== exp3[i]) begin failures++; $display("FAIL nowrap_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp3[i]); end
            end
        end
        checks++; if (addr_q.size() != 16) begin
            failures++; $display("FAIL nowrap_rd_en_pulses got=%0d exp=16", addr_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (addr_q[i] !== 4'(i)) begin failures++; $display("FAIL nowrap_rd_addr[%0d] got=%0d exp=%0d", i, addr_q[i], i); end
            end
        end
    endtask

    task automatic test_abort();
        bit      to;
        bit      found;
        byte_q_t exp;
        bus.tx_ready = 1'b1;
        start_frame(4'd2);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (xfer_q.size() == 11 && bus.tx_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin failures++; $display("FAIL abort_reach_sample7 not reached"); end
        checks++; if (bus.tx_data !== 8'hFF) begin failures++; $display("FAIL abort_sample7_data got=%h exp=FF", bus.tx_data); end
        abort = 1'b1;
        bus.tx_ready = 1'b0;
        tick();
        abort = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.rd_en !== 1'b0) begin
            failures++; $display("FAIL abort_idle valid=%b busy=%b rd_en=%b exp=0/0/0", bus.tx_valid, busy, bus.rd_en);
        end
        repeat (5) tick();
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        checks++; if (xfer_q.size() != 11) begin failures++; $display("FAIL abort_dropped_byte transfers=%0d exp=11", xfer_q.size()); end
        bus.tx_ready = 1'b1;
        start_frame(4'd9);
        wait_idle(300, 1'b0, to);
        exp = build_expected(4'd9);
        checks++; if (to) begin failures++; $display("FAIL abort_restart_timeout busy still high"); end
        checks++; if (xfer_q.size() != exp.size()) begin
            failures++; $display("FAIL abort_restart_len got=%0d exp=%0d", xfer_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (xfer_q[i] !== exp[i]) begin failures++; $display("FAIL abort_restart_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_double_edge();
        bit      to;
        byte_q_t exp;
        bus.tx_ready = 1'b1;
        start_frame(4'd3);
        tick();
        capture_done = 1'b0;
        tick();
        trigger_index = 4'd7;
        capture_done  = 1'b1;
        tick();
        wait_idle(300, 1'b0, to);
        exp = build_expected(4'd3);
        checks++; if (to) begin failures++; $display("FAIL dbl_timeout busy still high"); end
        checks++; if (xfer_q.size() != exp.size()) begin
            failures++; $display("FAIL dbl_len got=%0d exp=%0d", xfer_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (xfer_q[i] !== exp[i]) begin failures++; $display("FAIL dbl_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL dbl_done got=%0d exp=1", done_cnt); end
        repeat (5) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dbl_no_requeue busy=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        bit      to;
        byte_q_t exp;
        bus.tx_ready = 1'b1;
        start_frame(4'd2);
        for (int i = 0; i < 200; i++) begin
            if (xfer_q.size() >= 8) break;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL areset_tx_valid got=%b exp=0", bus.tx_valid); end
        checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL areset_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL areset_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.rd_addr !== 4'h0) begin failures++; $display("FAIL areset_rd_addr got=%h exp=0", bus.rd_addr); end
        checks++; if (busy !== 1'b0 || readout_done !== 1'b0) begin failures++; $display("FAIL areset_busy_done busy=%b done=%b exp=0/0", busy, readout_done); end
        @(negedge clk);
        #1;
        xfer_q.delete();
        addr_q.delete();
        done_cnt = 0;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || bus.tx_data !== 8'hA5) begin failures++; $display("FAIL areset_restart busy=%b data=%h exp=1/A5", busy, bus.tx_data); end
        wait_idle(300, 1'b0, to);
        exp = build_expected(4'd2);
        checks++; if (to) begin failures++; $display("FAIL areset_timeout busy still high"); end
        checks++; if (xfer_q.size() != exp.size()) begin
            failures++; $display("FAIL areset_len got=%0d exp=%0d", xfer_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++; if (xfer_q[i] !== exp[i]) begin failures++; $display("FAIL areset_byte[%0d] got=%h exp=%h", i, xfer_q[i], exp[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL areset_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        mem[5] = 8'hFF;
        bus.tx_ready = 1'b1;
        bus.rd_data  = 8'h00;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_no_wrap();
        test_abort();
        test_double_edge();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
